// File: rtl/cpu_run_controller.sv
`default_nettype none
// ============================================================================
// Module      : cpu_run_controller
// Description : Run controller for CPU bring-up and regression runs. It holds
//               the CPU in reset, counts RUN cycles, ends the run on a halt
//               PC, a PC stall or a cycle timeout, and folds the ALU results
//               into a rolling signature.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_run_controller #(
    parameter int          PC_W         = 32,
    parameter int          DATA_W       = 32,
    parameter int          CNT_W        = 32,
    parameter int          RESET_CYCLES = 5,
    parameter int          MAX_CYCLES   = 200000,
    parameter int          STALL_CYCLES = 16,
    parameter int          HALT_EN      = 1,
    parameter logic [31:0] HALT_PC      = 32'hFFFF_FFFC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   pc,
    input  logic [DATA_W-1:0] alu_result,
    output logic              cpu_rst,
    output logic              running,
    output logic              done,
    output logic [1:0]        status,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [DATA_W-1:0] signature,
    output logic [PC_W-1:0]   last_pc
);

    // Hold counter only has to reach RESET_CYCLES-1.
    localparam int c_HOLD_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    // Stall counter must be able to hold STALL_CYCLES itself.
    localparam int c_STALL_W = (STALL_CYCLES > 0) ? $clog2(STALL_CYCLES + 1) : 1;

    localparam logic [c_HOLD_W-1:0]  c_HOLD_LAST = c_HOLD_W'(RESET_CYCLES - 1);
    localparam logic [c_STALL_W-1:0] c_STALL_TGT = c_STALL_W'(STALL_CYCLES);
    localparam logic [CNT_W-1:0]     c_MAX_CNT   = CNT_W'(MAX_CYCLES);
    localparam logic [PC_W-1:0]      c_HALT_PC   = PC_W'(HALT_PC);

    localparam logic [1:0] c_ST_HALT    = 2'd1;
    localparam logic [1:0] c_ST_STALL   = 2'd2;
    localparam logic [1:0] c_ST_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state,       w_state;
    logic [c_HOLD_W-1:0]  r_hold_cnt,    w_hold_cnt;
    logic [c_STALL_W-1:0] r_stall_cnt,   w_stall_cnt;
    logic [PC_W-1:0]      r_pc_prev,     w_pc_prev;
    logic                 r_cpu_rst,     w_cpu_rst;
    logic                 r_running,     w_running;
    logic                 r_done,        w_done;
    logic [1:0]           r_status,      w_status;
    logic [CNT_W-1:0]     r_cycle_count, w_cycle_count;
    logic [DATA_W-1:0]    r_signature,   w_signature;
    logic [PC_W-1:0]      r_last_pc,     w_last_pc;

    // Candidate RUN-cycle updates; termination looks at these next values.
    logic [CNT_W-1:0]     w_cyc_inc;
    logic [DATA_W-1:0]    w_sig_upd;
    logic [c_STALL_W-1:0] w_stall_upd;
    logic                 w_halt_hit;
    logic                 w_stall_hit;
    logic                 w_timeout_hit;

    // Next-value datapath shared by the RUN state decisions.
    always_comb begin
        w_cyc_inc   = r_cycle_count + CNT_W'(1);
        w_sig_upd   = {r_signature[DATA_W-2:0], r_signature[DATA_W-1]} ^ alu_result;
        w_stall_upd = '0;
        if ((STALL_CYCLES != 0) && (pc == r_pc_prev)) begin
            // Saturate rather than wrap so a stall can never be missed.
            w_stall_upd = (r_stall_cnt == '1) ? r_stall_cnt
                                              : r_stall_cnt + c_STALL_W'(1);
        end
        w_halt_hit    = (HALT_EN != 0) && (pc == c_HALT_PC);
        w_stall_hit   = (STALL_CYCLES != 0) && (w_stall_upd == c_STALL_TGT);
        w_timeout_hit = (w_cyc_inc == c_MAX_CNT);
    end

    // Next-state and registered-output decode; defaults keep every value.
    always_comb begin
        w_state       = r_state;
        w_hold_cnt    = r_hold_cnt;
        w_stall_cnt   = r_stall_cnt;
        w_pc_prev     = r_pc_prev;
        w_cpu_rst     = r_cpu_rst;
        w_running     = r_running;
        w_done        = r_done;
        w_status      = r_status;
        w_cycle_count = r_cycle_count;
        w_signature   = r_signature;
        w_last_pc     = r_last_pc;
        case (r_state)
            S_HOLD: begin
                w_hold_cnt = r_hold_cnt + c_HOLD_W'(1);
                w_pc_prev  = pc;
                if (r_hold_cnt == c_HOLD_LAST) begin
                    w_state   = S_RUN;
                    w_cpu_rst = 1'b0;
                    w_running = 1'b1;
                end
            end
            S_RUN: begin
                w_cycle_count = w_cyc_inc;
                w_signature   = w_sig_upd;
                w_stall_cnt   = w_stall_upd;
                w_pc_prev     = pc;
                if (w_halt_hit || w_stall_hit || w_timeout_hit) begin
                    // Priority: halt over stall over timeout.
                    if (w_halt_hit) begin
                        w_status = c_ST_HALT;
                    end else if (w_stall_hit) begin
                        w_status = c_ST_STALL;
                    end else begin
                        w_status = c_ST_TIMEOUT;
                    end
                    w_last_pc = pc;
                    w_done    = 1'b1;
                    w_running = 1'b0;
                    w_cpu_rst = 1'b1;
                    w_state   = S_DONE;
                end
            end
            S_DONE: begin
                // Frozen until rst.
            end
            default: begin
                w_state = S_HOLD;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_HOLD;
            r_hold_cnt    <= '0;
            r_stall_cnt   <= '0;
            r_pc_prev     <= '0;
            r_cpu_rst     <= 1'b1;
            r_running     <= 1'b0;
            r_done        <= 1'b0;
            r_status      <= 2'd0;
            r_cycle_count <= '0;
            r_signature   <= '0;
            r_last_pc     <= '0;
        end else begin
            r_state       <= w_state;
            r_hold_cnt    <= w_hold_cnt;
            r_stall_cnt   <= w_stall_cnt;
            r_pc_prev     <= w_pc_prev;
            r_cpu_rst     <= w_cpu_rst;
            r_running     <= w_running;
            r_done        <= w_done;
            r_status      <= w_status;
            r_cycle_count <= w_cycle_count;
            r_signature   <= w_signature;
            r_last_pc     <= w_last_pc;
        end
    end

    assign cpu_rst     = r_cpu_rst;
    assign running     = r_running;
    assign done        = r_done;
    assign status      = r_status;
    assign cycle_count = r_cycle_count;
    assign signature   = r_signature;
    assign last_pc     = r_last_pc;

endmodule
`default_nettype wire
